// File: rtl/imem_loader_if.sv
// Byte-stream handshake carrying a program image into imem_loader.
// The master drives bytes; the loader (slave) answers with in_ready.
interface imem_loader_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams a program into a 2**ADDR_W x DATA_W memory, then serves registered fetches.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing modulo-2**DATA_W checksum byte after every payload.
module imem_loader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ld_start,
   input  logic [ADDR_W-1:0] ld_len,
   imem_loader_if.slave      stream,
   input  logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] inst,
   output logic              cpu_run,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] RUN   = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam logic [2:0] CHECK = 3'd2;
   localparam logic [2:0] ERR   = 3'd3;
`endif

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W:0]   remaining;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              accept;
   logic              load_accept;
   logic              last_byte;
   logic              load_begin;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;
`endif

   assign accept      = stream.in_valid & stream.in_ready;
   assign load_accept = (state == LOAD) & accept;
   assign last_byte   = (remaining == (ADDR_W + 1)'(1));
   assign load_begin  = (state != LOAD) & (state_nxt == LOAD);

   // Next-state logic; ld_start is honoured everywhere except while a load is already running.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (ld_start) state_nxt = LOAD;
         end
         LOAD: begin
            if (accept && last_byte) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_nxt = CHECK;
`else
               state_nxt = RUN;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHECK: begin
            if (accept) state_nxt = (stream.in_data == checksum) ? RUN : ERR;
         end
         ERR: begin
            if (ld_start) state_nxt = LOAD;
         end
`endif
         RUN: begin
            if (ld_start) state_nxt = LOAD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Status outputs decode straight from state so an asynchronous reset drops them at once.
   always_comb begin
      stream.in_ready = (state == LOAD);
      busy            = (state == LOAD);
      cpu_run         = (state == RUN);
      err             = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      stream.in_ready = (state == LOAD) | (state == CHECK);
      busy            = (state == LOAD) | (state == CHECK);
      err             = (state == ERR);
`endif
   end

   // Control and fetch registers; inst reads back as NOP whenever the pipeline is not running.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         done      <= 1'b0;
         inst      <= '0;
         waddr     <= '0;
         remaining <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         checksum  <= '0;
`endif
      end else begin
         state <= state_nxt;
         done  <= (state != RUN) & (state_nxt == RUN);
         inst  <= ((state == RUN) && (state_nxt == RUN)) ? mem[pc] : '0;
         if (load_begin) begin
            waddr     <= '0;
            remaining <= (ld_len == '0) ? (ADDR_W + 1)'(DEPTH) : {1'b0, ld_len};
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum  <= '0;
`endif
         end else if (load_accept) begin
            waddr     <= waddr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W + 1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum  <= checksum + stream.in_data;
`endif
         end
      end
   end

   // Memory array has no reset so a program survives a reset pulse.
   always_ff @(posedge clock) begin
      if (load_accept) mem[waddr] <= stream.in_data;
   end

endmodule
